// File: rtl/pc_seq.sv
// Program counter sequencer with trap/redirect/return selection and a circular return-address stack.
// Latency: PC and flags update one cycle after the selecting inputs; PCPlus4 is combinational from PC.
// Backpressure: PCWrite=0 freezes PC and RAS state; no other stall or credit path exists.
module pc_seq #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCWrite,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            misaligned_o,
    output logic            ras_ovf_o,
    output logic            ras_unf_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ptr_q;
    logic [CW-1:0]   cnt_q;
    logic            mis_q;
    logic            ovf_q;
    logic            unf_q;

    logic [PW-1:0]   top_idx;
    logic [XLEN-1:0] top_val;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] pc_nxt;
    logic            empty;
    logic            full;
    logic            do_ret;
    logic            pop;
    logic            push;
    logic            replace;
    logic            load;
    logic            mis_nxt;
    logic            ovf_set;
    logic            unf_set;

    // ptr_q always points at the next free slot; the top of stack sits just below it.
    always_comb begin
        top_idx  = ptr_q - PW'(1);
        top_val  = ras_mem[top_idx];
        pc_plus4 = pc_q + XLEN'(4);
        empty    = (cnt_q == CW'(0));
        full     = (cnt_q == CW'(RAS_DEPTH));
    end

    always_comb begin
        do_ret  = !trap_i && !redirect_i && ret_i;
        pop     = do_ret && !empty;
        // A call paired with a popping return swaps the top entry instead of growing the stack.
        replace = !trap_i && call_i && pop;
        push    = !trap_i && call_i && !pop;
        load    = trap_i || redirect_i || pop;

        src = pc_plus4;
        if (trap_i)
            src = trap_vector;
        else if (redirect_i)
            src = redirect_target;
        else if (pop)
            src = top_val;

        pc_nxt  = {src[XLEN-1:2], 2'b00};
        mis_nxt = load && (src[1:0] != 2'b00);
        ovf_set = push && full;
        unf_set = do_ret && empty;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_VECTOR;
            ptr_q <= '0;
            cnt_q <= '0;
            mis_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            mis_q <= PCWrite && mis_nxt;
            if (PCWrite) begin
                pc_q <= pc_nxt;
                if (trap_i) begin
                    ptr_q <= '0;
                    cnt_q <= '0;
                end else if (push) begin
                    ptr_q <= ptr_q + PW'(1);
                    if (!full)
                        cnt_q <= cnt_q + CW'(1);
                end else if (pop && !replace) begin
                    ptr_q <= top_idx;
                    cnt_q <= cnt_q - CW'(1);
                end
                if (ovf_set)
                    ovf_q <= 1'b1;
                if (unf_set)
                    unf_q <= 1'b1;
            end
        end
    end

    // Stack storage carries no reset; stale entries are unreachable once the count is cleared.
    always_ff @(posedge clk) begin
        if (rst && PCWrite) begin
            if (replace)
                ras_mem[top_idx] <= pc_plus4;
            else if (push)
                ras_mem[ptr_q] <= pc_plus4;
        end
    end

    assign PC           = pc_q;
    assign PCPlus4      = pc_plus4;
    assign ras_empty    = empty;
    assign ras_full     = full;
    assign misaligned_o = mis_q;
    assign ras_ovf_o    = ovf_q;
    assign ras_unf_o    = unf_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: reset, sequencing, RAS push/pop/overflow/underflow, trap, alignment, wrap.
module tb_pc_seq;

    logic        clk;
    logic        rst;
    logic        PCWrite;
    logic        trap_i;
    logic [31:0] trap_vector;
    logic        redirect_i;
    logic [31:0] redirect_target;
    logic        call_i;
    logic        ret_i;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        ras_empty;
    logic        ras_full;
    logic        misaligned_o;
    logic        ras_ovf_o;
    logic        ras_unf_o;

    int n_chk  = 0;
    int n_fail = 0;

    pc_seq #(.XLEN(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .PCWrite         (PCWrite),
        .trap_i          (trap_i),
        .trap_vector     (trap_vector),
        .redirect_i      (redirect_i),
        .redirect_target (redirect_target),
        .call_i          (call_i),
        .ret_i           (ret_i),
        .PC              (PC),
        .PCPlus4         (PCPlus4),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full),
        .misaligned_o    (misaligned_o),
        .ras_ovf_o       (ras_ovf_o),
        .ras_unf_o       (ras_unf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        trap_i = 0; redirect_i = 0; call_i = 0; ret_i = 0;
    endtask

    initial begin
        rst = 0; PCWrite = 0; idle();
        trap_vector = '0; redirect_target = '0;
        #1;
        chk("rst_pc", PC, 32'h0);
        chk("rst_empty", ras_empty, 1);
        chk("rst_full", ras_full, 0);
        chk("rst_flags", {misaligned_o, ras_ovf_o, ras_unf_o}, 0);

        @(negedge clk);
        rst = 1; PCWrite = 1;
        chk("rel_pc", PC, 32'h0);
        step(); chk("seq1", PC, 32'h4);
        step(); chk("seq2", PC, 32'h8);
        step(); chk("seq3", PC, 32'hC);
        chk("seq_empty", ras_empty, 1);

        redirect_i = 1; redirect_target = 32'h100;
        step(); chk("redir_100", PC, 32'h100);
        call_i = 1; redirect_target = 32'h400;
        step(); chk("call_pc", PC, 32'h400);
        chk("call_nonempty", ras_empty, 0);
        idle(); ret_i = 1;
        step(); chk("ret_pc", PC, 32'h104);
        chk("ret_empty", ras_empty, 1);

        idle(); redirect_i = 1; redirect_target = 32'h0;
        step(); chk("redir_0", PC, 32'h0);
        call_i = 1;
        for (int i = 1; i <= 4; i++) begin
            redirect_target = 32'(i * 16);
            step();
        end
        chk("four_calls_pc", PC, 32'h40);
        chk("four_full", ras_full, 1);
        chk("four_no_ovf", ras_ovf_o, 0);
        redirect_target = 32'h80;
        step(); chk("ovf_set", ras_ovf_o, 1);
        chk("ovf_full", ras_full, 1);
        idle(); ret_i = 1;
        step(); chk("pop1", PC, 32'h44);
        step(); chk("pop2", PC, 32'h34);
        step(); chk("pop3", PC, 32'h24);
        step(); chk("pop4", PC, 32'h14);
        chk("pop4_empty", ras_empty, 1);
        chk("pop4_no_unf", ras_unf_o, 0);
        step(); chk("unf_pc", PC, 32'h18);
        chk("unf_set", ras_unf_o, 1);

        idle(); call_i = 1; redirect_i = 1; redirect_target = 32'h300;
        step(); chk("call_300", PC, 32'h300);
        idle(); PCWrite = 0; trap_i = 1; call_i = 1; trap_vector = 32'h800;
        step(); chk("stall_pc", PC, 32'h300);
        chk("stall_cnt", ras_empty, 0);
        chk("stall_mis", misaligned_o, 0);
        PCWrite = 1;
        step(); chk("trap_pc", PC, 32'h800);
        chk("trap_flush", ras_empty, 1);

        idle(); call_i = 1; redirect_i = 1; redirect_target = 32'h500;
        step(); chk("call_500", PC, 32'h500);
        idle(); call_i = 1; ret_i = 1;
        step(); chk("callret_pc", PC, 32'h804);
        chk("callret_cnt", {ras_empty, ras_full}, 2'b00);
        idle(); ret_i = 1;
        step(); chk("swap_top", PC, 32'h504);
        chk("swap_empty", ras_empty, 1);

        idle(); redirect_i = 1; redirect_target = 32'h203;
        step(); chk("mis_pc", PC, 32'h200);
        chk("mis_pulse", misaligned_o, 1);
        idle();
        step(); chk("mis_seq_pc", PC, 32'h204);
        chk("mis_clear", misaligned_o, 0);
        trap_i = 1; trap_vector = 32'h802;
        step(); chk("trap_mis_pc", PC, 32'h800);
        chk("trap_mis", misaligned_o, 1);
        idle(); redirect_i = 1; redirect_target = 32'hFFFF_FFFC;
        step(); chk("top_pc", PC, 32'hFFFF_FFFC);
        chk("top_plus4", PCPlus4, 32'h0);
        idle();
        step(); chk("wrap_pc", PC, 32'h0);

        call_i = 1; ret_i = 1;
        step(); chk("callret_empty_pc", PC, 32'h4);
        chk("callret_empty_push", ras_empty, 0);

        idle(); call_i = 1; redirect_i = 1; redirect_target = 32'h600;
        #2 rst = 0;
        #1;
        chk("arst_pc", PC, 32'h0);
        chk("arst_empty", ras_empty, 1);
        chk("arst_flags", {misaligned_o, ras_ovf_o, ras_unf_o}, 0);
        step(); chk("arst_hold", PC, 32'h0);
        idle(); rst = 1;
        step(); chk("post_rst_pc", PC, 32'h4);
        chk("post_rst_empty", ras_empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
Parameters:
REQ-001 XLEN, 32, PC width in bits; legal range 16..64.
REQ-002 RESET_VECTOR, 0, PC value loaded on reset; must be 4-byte aligned.
REQ-003 RAS_DEPTH, 4, return-address-stack entries; power of two, 2..16.

Ports:
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 PCWrite  in  1  advance enable from Control Unit; 0 = stall.
REQ-007 trap_i  in  1  take trap this cycle.
REQ-008 trap_vector  in  XLEN  trap target.
REQ-009 redirect_i  in  1  branch/jump taken.
REQ-010 redirect_target  in  XLEN  branch/jump target.
REQ-011 call_i  in  1  current instruction is a call; push PC+4.
REQ-012 ret_i  in  1  current instruction is a return; pop RAS.
REQ-013 PC  out  XLEN  current program counter, registered.
REQ-014 PCPlus4  out  XLEN  PC+4, combinational, modulo 2^XLEN.
REQ-015 ras_empty  out  1  RAS holds 0 entries.
REQ-016 ras_full  out  1  RAS holds RAS_DEPTH entries.
REQ-017 misaligned_o  out  1  registered one-cycle pulse: last loaded target had bits[1:0] != 0.
REQ-018 ras_ovf_o  out  1  sticky: a push occurred while full.
REQ-019 ras_unf_o  out  1  sticky: a pop occurred while empty.

Function
REQ-020 PCWrite=0 shall hold PC, RAS contents, RAS count and pointer; misaligned_o shall be 0; sticky flags shall hold.
REQ-021 With PCWrite=1, next-PC priority shall be trap_i > redirect_i > ret_i > sequential (PC+4).
REQ-022 trap_i=1 shall load trap_vector, flush the RAS (count=0), and ignore call_i/ret_i.
REQ-023 redirect_i=1 without trap shall load redirect_target; ret_i shall be ignored for target selection and shall not pop.
REQ-024 ret_i=1 (no trap, no redirect) with RAS non-empty shall load the top entry and pop (count-1).
REQ-025 ret_i=1 with RAS empty shall load PC+4 and set ras_unf_o.
REQ-026 call_i=1 (no trap) shall push PC+4 of the current PC, regardless of redirect_i.
REQ-027 A push when full shall overwrite the oldest entry (circular), keep count=RAS_DEPTH, and set ras_ovf_o.
REQ-028 call_i and ret_i together, with no redirect and RAS non-empty: load top, replace top with PC+4, count unchanged; with RAS empty: plain push, load PC+4, set ras_unf_o.
REQ-029 Every loaded target shall have bits[1:0] forced to 0; misaligned_o shall pulse in the cycle after a load whose source bits[1:0] != 0.
REQ-030 Sequential increment shall wrap modulo 2^XLEN (all-ones-minus-3 -> 0) without flag.
REQ-031 Pushed RAS values shall be stored as full XLEN values; popped values shall be re-aligned per REQ-029.
REQ-032 ras_empty/ras_full shall be derived from the registered count, with no combinational path from inputs.

Reset
REQ-033 rst low shall immediately, independent of clk, set PC=RESET_VECTOR, RAS count=0, pointer=0, misaligned_o=0, ras_ovf_o=0, ras_unf_o=0.
REQ-034 Reset asserted mid-operation shall discard any in-flight push/pop; RAS entry contents need not be cleared.
REQ-035 First update after rst deasserts shall occur on the first rising edge with PCWrite=1.

Verification
REQ-036 Reset release, PCWrite=1 for 3 cycles, RESET_VECTOR=0 -> PC 0x0, 0x4, 0x8, 0xC; ras_empty=1.
REQ-037 PC=0x100, call_i+redirect_i target 0x400; then ret_i -> PC 0x400, then 0x104; ras_empty=1 after the pop.
REQ-038 RAS_DEPTH=4, 5 calls from PCs 0x0,0x10,0x20,0x30,0x40 -> ras_full=1, ras_ovf_o=1; 4 rets return 0x44,0x34,0x24,0x14; 5th ret -> PC+4, ras_unf_o=1.
REQ-039 PCWrite=0 with trap_i=1 and call_i=1 -> PC, count unchanged; PCWrite=1 same inputs -> PC=trap_vector, ras_empty=1, no push.
REQ-040 redirect_target 0x203 -> PC=0x200, misaligned_o=1 for exactly one cycle; PC=0xFFFFFFFC sequential -> PC=0x0.
REQ-041 Assert rst low between edges during a call -> PC=RESET_VECTOR asynchronously, ras_empty=1, flags cleared.
